regfile_lfsr_gen: RTL and testbench
===================================

# regfile_lfsr_gen

Parametrised second-generation register file for the CSE141L datapath: 2**A general registers of W bits, two combinational read ports, one synchronous write port, and an integrated L-bit Fibonacci LFSR whose seed and tap mask are software-writable through the same write port. Either read port can be switched to return the LFSR state. A hardware bulk-clear sequencer zeroes the register array one entry per cycle. The block sits between decode and the ALU, replacing the fixed 8×8 register file and its fixed-tap LFSR.

## Interface
- W, 8, data path width
- A, 3, address width; depth = 2**A
- L, 7, LFSR width; 2 ≤ L ≤ W
- TAP_DEFAULT, 7'h60, LFSR tap mask loaded at reset (x^7+x^6+1, maximal for L=7)

- Clk  input  1  clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- RegWrite  input  1  write enable
- RegDest  input  2  write target: 00 register, 01 LFSR seed, 10 tap mask, 11 none
- Waddr  input  A  register write address
- DataIn  input  W  write data
- RaddrA, RaddrB  input  A  read addresses
- SelA, SelB  input  1  0: register; 1: LFSR state zero-extended to W
- NextLFSR  input  1  advance LFSR one step
- Clear  input  1  request bulk clear of the register array
- Busy  output  1  clear sequence in progress
- DataOutA, DataOutB  output  W  combinational read data
- LfsrState  output  L  current LFSR state

## Operation
- Reads are combinational and never stall, including during a clear.
- Register write occurs when RegWrite=1, RegDest=00, Busy=0. It is dropped when Busy=1.
- Seed write occurs when RegWrite=1 and RegDest=01: State ← DataIn[L-1:0]. A zero value loads 1 instead.
- Tap write occurs when RegWrite=1 and RegDest=10: Taps ← DataIn[L-1:0].
- RegDest=11 writes nothing.
- Step: when NextLFSR=1 and no seed write is active, State ← {State[L-2:0], ^(State & Taps)}.
- Zero guard: if a computed next state equals 0, State ← 1. Every update path is guarded, so State is never 0.
- Seed write and NextLFSR in the same cycle: the seed wins and no step occurs.
- Tap write and NextLFSR in the same cycle: the step uses the old Taps.
- Clear FSM has two states, IDLE and CLEAR, and an A-bit index.
  - IDLE → CLEAR when Clear=1; index ← 0.
  - In CLEAR, Registers[index] ← 0 and index increments each cycle.
  - After writing index 2**A−1 the FSM returns to IDLE.
  - Clear=1 while in CLEAR is ignored; the sequence does not restart.
  - LFSR seed, tap and step operations proceed normally during CLEAR.
- Busy = (state == CLEAR).
- Reset mid-clear aborts the sequence. All registers are zeroed by reset anyway.

## Timing
- Reset values:
  - all registers 0; State 1; Taps TAP_DEFAULT; FSM IDLE; index 0.
  - Busy 0; LfsrState 1.
  - DataOutA/B are 0 with Sel=0, or 1 with Sel=1.
- Write latency: data is visible on reads in the cycle after the write edge (see Configuration for same-cycle bypass).
- Clear: Clear sampled at edge N puts Busy high from after edge N for exactly 2**A cycles. Entry i is zero after edge N+1+i.
- Busy is registered; it does not depend combinationally on Clear.
- LFSR: one step per edge with NextLFSR=1; LfsrState updates after the edge.

## Configuration
- REGFILE_BYPASS_EN defined: a read port with Sel=0 whose address equals Waddr returns DataIn combinationally in the cycle of an accepted register write (RegWrite=1, RegDest=00, Busy=0).
  - No bypass applies to dropped writes.
  - No bypass applies to LFSR reads.
- REGFILE_BYPASS_EN undefined: reads always return pre-edge array contents.

## Test plan
- Reset, then read all 8 addresses with SelA=SelB=0 → all 0x00. Read with SelA=1 → DataOutA=0x01.
- Write 0xA5 to r3, then read r3 on both ports next cycle → 0xA5. In the write cycle, r3 reads 0xA5 with REGFILE_BYPASS_EN defined and 0x00 without it.
- Seed 0x01 with default taps, then NextLFSR for 7 cycles → LfsrState 0x02, 0x04, 0x08, 0x10, 0x20, 0x41, 0x03. After 127 total steps → 0x01.
- Seed write of 0x00 → LfsrState 0x01. Seed write of 0x55 in the same cycle as NextLFSR=1 → LfsrState 0x55.
- Fill r0–r7 with 0xFF, pulse Clear for 1 cycle → Busy high exactly 8 cycles. A write of 0x11 to r2 during Busy is dropped. Afterwards all registers read 0x00.
- Assert Reset_n=0 on the 3rd cycle of a clear → Busy falls immediately (asynchronously). Registers read 0, State is 1, and no further clear activity occurs after reset release.

Source files
------------

// File: rtl/regfile_lfsr_gen.sv
// rtl/regfile_lfsr_gen.sv - register file with integrated Fibonacci LFSR and bulk-clear sequencer
//
// Purpose:
//   2**A x W general register file with two combinational read ports and one
//   synchronous write port. It also holds an L-bit Fibonacci LFSR whose seed
//   and tap mask are loaded through the same write port. A two-state
//   sequencer zeroes the array one entry per cycle when Clear is pulsed.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, an accepted register write is forwarded
//   combinationally to any register read (Sel=0) of the same address.
//
// Ports:
//   Clk                 clock, rising edge
//   Reset_n             asynchronous active-low reset
//   RegWrite            write enable
//   RegDest[1:0]        00 register, 01 LFSR seed, 10 tap mask, 11 none
//   Waddr[A-1:0]        register write address
//   DataIn[W-1:0]       write data
//   RaddrA/RaddrB       read addresses
//   SelA/SelB           1 selects the zero-extended LFSR state
//   NextLFSR            advance the LFSR one step
//   Clear               start a bulk clear of the array
//   Busy                clear sequence in progress
//   DataOutA/DataOutB   combinational read data
//   LfsrState[L-1:0]    current LFSR state

module regfile_lfsr_gen #(
  parameter int               W           = 8,
  parameter int               A           = 3,
  parameter int               L           = 7,
  parameter logic [L-1:0]     TAP_DEFAULT = 7'h60
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         RegWrite,
  input  logic [1:0]   RegDest,
  input  logic [A-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  input  logic         SelA,
  input  logic         SelB,
  input  logic         NextLFSR,
  input  logic         Clear,
  output logic         Busy,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  output logic [L-1:0] LfsrState
);

  localparam int           DEPTH    = 2 ** A;
  localparam logic [A-1:0] LAST_IDX = A'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   idx_q, idx_d;
  logic           clr_we;

  logic [W-1:0]   regs_q [DEPTH];
  logic [L-1:0]   lfsr_q, lfsr_d;
  logic [L-1:0]   taps_q;
  logic [L-1:0]   lfsr_step;
  logic [W-1:0]   lfsr_ext;

  logic           reg_we, seed_we, tap_we;

  assign Busy    = (state_q == S_CLEAR);
  assign reg_we  = RegWrite && (RegDest == 2'b00) && !Busy;
  assign seed_we = RegWrite && (RegDest == 2'b01);
  assign tap_we  = RegWrite && (RegDest == 2'b10);

  // Clear sequencer
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Clear) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        // Clear is ignored here so a second pulse cannot restart the sweep.
        clr_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register array; sweep writes and port writes are exclusive via Busy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (clr_we) begin
      regs_q[idx_q] <= '0;
    end else if (reg_we) begin
      regs_q[Waddr] <= DataIn;
    end
  end

  // LFSR: seed beats step; step always uses the taps held before this edge.
  assign lfsr_step = {lfsr_q[L-2:0], ^(lfsr_q & taps_q)};

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_we) begin
      lfsr_d = DataIn[L-1:0];
    end else if (NextLFSR) begin
      lfsr_d = lfsr_step;
    end
    // All-zero is the lock-up state of an XOR LFSR; never let it in.
    if (lfsr_d == '0) begin
      lfsr_d = L'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_q <= L'(1);
      taps_q <= TAP_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
      if (tap_we) begin
        taps_q <= DataIn[L-1:0];
      end
    end
  end

  assign LfsrState = lfsr_q;
  assign lfsr_ext  = W'(lfsr_q);

  // Read ports
  always_comb begin
    DataOutA = regs_q[RaddrA];
`ifdef REGFILE_BYPASS_EN
    if (reg_we && (RaddrA == Waddr)) begin
      DataOutA = DataIn;
    end
`endif
    if (SelA) begin
      DataOutA = lfsr_ext;
    end
  end

  always_comb begin
    DataOutB = regs_q[RaddrB];
`ifdef REGFILE_BYPASS_EN
    if (reg_we && (RaddrB == Waddr)) begin
      DataOutB = DataIn;
    end
`endif
    if (SelB) begin
      DataOutB = lfsr_ext;
    end
  end

endmodule

// File: tb/tb_regfile_lfsr_gen.sv
// tb/tb_regfile_lfsr_gen.sv - self-checking bench for regfile_lfsr_gen

module tb_regfile_lfsr_gen;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       Clk;
  logic       Reset_n;
  logic       RegWrite;
  logic [1:0] RegDest;
  logic [2:0] Waddr;
  logic [7:0] DataIn;
  logic [2:0] RaddrA, RaddrB;
  logic       SelA, SelB;
  logic       NextLFSR;
  logic       Clear;
  logic       Busy;
  logic [7:0] DataOutA, DataOutB;
  logic [6:0] LfsrState;

  regfile_lfsr_gen #(.W(8), .A(3), .L(7), .TAP_DEFAULT(7'h60)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .RegWrite  (RegWrite),
    .RegDest   (RegDest),
    .Waddr     (Waddr),
    .DataIn    (DataIn),
    .RaddrA    (RaddrA),
    .RaddrB    (RaddrB),
    .SelA      (SelA),
    .SelB      (SelB),
    .NextLFSR  (NextLFSR),
    .Clear     (Clear),
    .Busy      (Busy),
    .DataOutA  (DataOutA),
    .DataOutB  (DataOutB),
    .LfsrState (LfsrState)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       rw;
    logic [1:0] rd;
    logic [2:0] wa;
    logic [7:0] di;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       sa;
    logic       sb;
    logic       nx;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       bpa;
    logic       bpb;
    logic [6:0] exp_l;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0; RegDest = 2'b11; Waddr = 3'd0; DataIn = 8'h00;
    RaddrA = 3'd0; RaddrB = 3'd0; SelA = 1'b0; SelB = 1'b0;
    NextLFSR = 1'b0; Clear = 1'b0;
  endtask

  task automatic wr(input logic [1:0] dest, input logic [2:0] a, input logic [7:0] d);
    @(negedge Clk);
    idle_inputs();
    RegWrite = 1'b1; RegDest = dest; Waddr = a; DataIn = d;
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] ea, eb;

    // {rw, rd, wa, di, ra, rb, sa, sb, nx, exp_a, exp_b, bpa, bpb, exp_l}
    vt[0]  = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 7'h01};
    vt[1]  = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 7'h01};
    vt[2]  = '{1'b1, 2'd0, 3'd3, 8'hA5, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 7'h01};
    vt[3]  = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 7'h01};
    vt[4]  = '{1'b1, 2'd0, 3'd7, 8'h5A, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 7'h01};
    vt[5]  = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h01, 1'b0, 1'b0, 7'h01};
    vt[6]  = '{1'b1, 2'd3, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 7'h01};
    vt[7]  = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 7'h01};
    vt[8]  = '{1'b1, 2'd1, 3'd0, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 7'h01};
    vt[9]  = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 7'h01};
    vt[10] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 1'b0, 1'b0, 7'h02};
    vt[11] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 7'h04};
    vt[12] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h08, 8'h00, 1'b0, 1'b0, 7'h08};
    vt[13] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 7'h10};
    vt[14] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 7'h20};
    vt[15] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h41, 8'h00, 1'b0, 1'b0, 7'h41};
    vt[16] = '{1'b1, 2'd1, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 7'h03};
    vt[17] = '{1'b1, 2'd1, 3'd0, 8'h55, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 7'h01};
    vt[18] = '{1'b1, 2'd2, 3'd0, 8'h03, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, 7'h55};
    vt[19] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h2B, 8'h00, 1'b0, 1'b0, 7'h2B};
    vt[20] = '{1'b1, 2'd2, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 7'h56};
    vt[21] = '{1'b1, 2'd1, 3'd0, 8'h40, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 7'h56};
    vt[22] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 7'h40};
    vt[23] = '{1'b1, 2'd2, 3'd0, 8'h60, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 7'h01};
    vt[24] = '{1'b1, 2'd1, 3'd0, 8'hFF, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 7'h01};
    vt[25] = '{1'b1, 2'd1, 3'd0, 8'h80, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 7'h7F};
    vt[26] = '{1'b0, 2'd0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0, 7'h01};

    idle_inputs();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Reset state on every address
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      idle_inputs();
      RaddrA = 3'(i); RaddrB = 3'(7 - i);
      #1;
      check($sformatf("reset_rdA_r%0d", i), DataOutA, 8'h00);
      check($sformatf("reset_rdB_r%0d", 7 - i), DataOutB, 8'h00);
    end
    check("reset_busy", Busy, 1'b0);
    check("reset_lfsr", LfsrState, 7'h01);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      idle_inputs();
      RegWrite = vt[i].rw; RegDest = vt[i].rd; Waddr = vt[i].wa; DataIn = vt[i].di;
      RaddrA = vt[i].ra; RaddrB = vt[i].rb; SelA = vt[i].sa; SelB = vt[i].sb;
      NextLFSR = vt[i].nx;
      #1;
      ea = (BYP && vt[i].bpa) ? vt[i].di : vt[i].exp_a;
      eb = (BYP && vt[i].bpb) ? vt[i].di : vt[i].exp_b;
      check($sformatf("vec%0d_DataOutA", i), DataOutA, ea);
      check($sformatf("vec%0d_DataOutB", i), DataOutB, eb);
      check($sformatf("vec%0d_LfsrState", i), LfsrState, vt[i].exp_l);
      check($sformatf("vec%0d_Busy", i), Busy, 1'b0);
    end

    // Full period of the maximal LFSR from seed 0x01
    wr(2'b01, 3'd0, 8'h01);
    for (int s = 1; s <= 127; s++) begin
      @(negedge Clk);
      idle_inputs();
      NextLFSR = 1'b1;
      #1;
      if (s == 8) check("lfsr_after_7", LfsrState, 7'h03);
    end
    @(negedge Clk);
    idle_inputs();
    #1;
    check("lfsr_after_127", LfsrState, 7'h01);

    // Bulk clear
    for (int i = 0; i < 8; i++) wr(2'b00, 3'(i), 8'hFF);
    @(negedge Clk);
    idle_inputs();
    RaddrA = 3'd5;
    Clear = 1'b1;
    #1;
    check("clear_busy_not_comb", Busy, 1'b0);
    check("clear_prefill_r5", DataOutA, 8'hFF);
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      idle_inputs();
      Clear    = (k == 3);
      NextLFSR = (k == 0);
      if (k == 7) begin
        RegWrite = 1'b1; RegDest = 2'b00; Waddr = 3'd2; DataIn = 8'h11;
        RaddrA = 3'd2; RaddrB = 3'd7;
      end else begin
        RaddrA = 3'(k);
        RaddrB = (k == 0) ? 3'd0 : 3'(k - 1);
      end
      #1;
      if (Busy) busy_cnt++;
      check($sformatf("clear_k%0d_rdA", k), DataOutA, (k == 7) ? 8'h00 : 8'hFF);
      check($sformatf("clear_k%0d_rdB", k), DataOutB, (k == 0 || k == 7) ? 8'hFF : 8'h00);
      if (k == 1) check("clear_lfsr_step", LfsrState, 7'h02);
    end
    check("clear_busy_cycles", busy_cnt, 8);
    @(negedge Clk);
    idle_inputs();
    #1;
    check("clear_busy_end", Busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      idle_inputs();
      RaddrA = 3'(i);
      #1;
      check($sformatf("after_clear_r%0d", i), DataOutA, 8'h00);
    end

    // Reset during a clear
    wr(2'b00, 3'd7, 8'h77);
    wr(2'b01, 3'd0, 8'h55);
    @(negedge Clk);
    idle_inputs();
    Clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      idle_inputs();
      RaddrA = 3'd7;
      #1;
      check($sformatf("rst_clear_k%0d_busy", k), Busy, 1'b1);
    end
    Reset_n = 1'b0;
    #1;
    check("rst_busy_async", Busy, 1'b0);
    check("rst_r7", DataOutA, 8'h00);
    check("rst_lfsr", LfsrState, 7'h01);
    @(negedge Clk);
    Reset_n = 1'b1;
    wr(2'b00, 3'd7, 8'h33);
    busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      idle_inputs();
      RaddrA = 3'd7;
      #1;
      if (Busy) busy_cnt++;
    end
    check("post_rst_busy_cycles", busy_cnt, 0);
    check("post_rst_r7", DataOutA, 8'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
